// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the byte-serialising memory port arbiter.
package mem_port_arbiter_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] IO_REGION  = 2'b11;

    typedef enum logic [1:0] {
        MEM_ST_IDLE,
        MEM_ST_READ,
        MEM_ST_WRITE,
        MEM_ST_IO_WAIT
    } mem_st_e;

    // Size code 3 is illegal and widened to a full word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: return 3'd1;
            MEM_SIZE_H: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response channels plus the byte-wide RAM/IO bus of the arbiter.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32
);
    logic [NUM_CH-1:0]             req_valid;
    logic [NUM_CH-1:0]             req_wr;
    logic [NUM_CH-1:0][1:0]        req_size;
    logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_CH-1:0][31:0]       req_wdata;
    logic [NUM_CH-1:0]             resp_valid;
    logic [31:0]                   resp_data;
    logic [7:0]                    mem_din;
    logic [7:0]                    mem_dout;
    logic [ADDR_W-1:0]             mem_a;
    logic                          mem_wr;
    logic                          io_buffer_full;

    modport master (
        input  req_valid, req_wr, req_size, req_addr, req_wdata, mem_din, io_buffer_full,
        output resp_valid, resp_data, mem_dout, mem_a, mem_wr
    );

    modport slave (
        output req_valid, req_wr, req_size, req_addr, req_wdata, mem_din, io_buffer_full,
        input  resp_valid, resp_data, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_idx
);
    // Scan farthest-first so the nearest requester overwrites earlier hits.
    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (i_req[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = CH_W'(j);
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising 1/2/4-byte little-endian accesses onto a byte-wide RAM/IO bus.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                ADDR_W      = 32,
    parameter logic [NUM_CH-1:0] CANCEL_MASK = {NUM_CH{1'b1}}
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic rdy_in,
    input  logic rollback,
    output logic busy,
    mem_port_arbiter_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    mem_st_e           r_state, w_state_nx;
    logic [CH_W-1:0]   r_ptr, w_ptr_nx, r_ch, w_ch_nx;
    logic              r_wr, w_wr_nx;
    logic [2:0]        r_n, w_n_nx, r_iss, w_iss_nx;
    logic [1:0]        r_cap, w_cap_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [31:0]       r_wdata, w_wdata_nx, r_rdata, w_rdata_nx;
    logic [1:0]        r_rd_pipe, w_rd_pipe_nx;
    logic [ADDR_W-1:0] r_mem_a, w_mem_a_nx;
    logic [7:0]        r_mem_dout, w_mem_dout_nx;
    logic              r_mem_wr, w_mem_wr_nx;
    logic [NUM_CH-1:0] r_resp_valid, w_resp_valid_nx;
    logic [31:0]       r_resp_data, w_resp_data_nx;

    logic [NUM_CH-1:0] w_gnt;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_gnt_any, w_g_wr, w_g_io_blk, w_cancel;
    logic [1:0]        w_g_size;
    logic [ADDR_W-1:0] w_g_addr, w_iss_addr;
    logic [31:0]       w_g_wdata, w_rdata_mrg;
    logic [7:0]        w_iss_byte;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    assign w_gnt_any  = |w_gnt;
    assign w_g_wr     = bus.req_wr[w_gnt_idx];
    assign w_g_size   = bus.req_size[w_gnt_idx];
    assign w_g_addr   = bus.req_addr[w_gnt_idx];
    assign w_g_wdata  = bus.req_wdata[w_gnt_idx];
    assign w_g_io_blk = w_g_wr && (w_g_addr[17:16] == IO_REGION) && bus.io_buffer_full;
    // IO reads consume UART input, so they survive a rollback.
    assign w_cancel   = rollback && CANCEL_MASK[r_ch] && (r_addr[17:16] != IO_REGION);
    assign w_iss_addr = r_addr + ADDR_W'(r_iss);
    assign w_iss_byte = r_wdata[{r_iss[1:0], 3'b000} +: 8];

    always_comb begin
        w_rdata_mrg = r_rdata;
        w_rdata_mrg[{r_cap, 3'b000} +: 8] = bus.mem_din;
    end

    // r_rd_pipe[0]: a read address is on the bus; [1]: its byte is on mem_din.
    always_comb begin
        w_state_nx      = r_state;
        w_ptr_nx        = r_ptr;
        w_ch_nx         = r_ch;
        w_wr_nx         = r_wr;
        w_n_nx          = r_n;
        w_addr_nx       = r_addr;
        w_wdata_nx      = r_wdata;
        w_iss_nx        = r_iss;
        w_cap_nx        = r_cap;
        w_rdata_nx      = r_rdata;
        w_rd_pipe_nx    = {r_rd_pipe[0], 1'b0};
        w_mem_a_nx      = '0;
        w_mem_dout_nx   = '0;
        w_mem_wr_nx     = 1'b0;
        w_resp_valid_nx = '0;
        w_resp_data_nx  = r_resp_data;
        case (r_state)
            MEM_ST_IDLE: if (w_gnt_any) begin
                w_ch_nx    = w_gnt_idx;
                w_wr_nx    = w_g_wr;
                w_n_nx     = size_to_bytes(w_g_size);
                w_addr_nx  = w_g_addr;
                w_wdata_nx = w_g_wdata;
                w_ptr_nx   = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
                w_iss_nx   = 3'd1;
                w_cap_nx   = '0;
                w_rdata_nx = '0;
                if (w_g_io_blk) begin
                    w_state_nx = MEM_ST_IO_WAIT;
                end else if (w_g_wr) begin
                    w_state_nx    = MEM_ST_WRITE;
                    w_mem_a_nx    = w_g_addr;
                    w_mem_dout_nx = w_g_wdata[7:0];
                    w_mem_wr_nx   = 1'b1;
                end else begin
                    w_state_nx      = MEM_ST_READ;
                    w_mem_a_nx      = w_g_addr;
                    w_rd_pipe_nx[0] = 1'b1;
                end
            end
            MEM_ST_READ: if (w_cancel) begin
                w_state_nx   = MEM_ST_IDLE;
                w_rd_pipe_nx = '0;
            end else begin
                if (r_iss < r_n) begin
                    w_mem_a_nx      = w_iss_addr;
                    w_rd_pipe_nx[0] = 1'b1;
                    w_iss_nx        = r_iss + 3'd1;
                end
                if (r_rd_pipe[1]) begin
                    w_rdata_nx = w_rdata_mrg;
                    w_cap_nx   = r_cap + 2'd1;
                    if ({1'b0, r_cap} == r_n - 3'd1) begin
                        w_state_nx            = MEM_ST_IDLE;
                        w_resp_valid_nx[r_ch] = 1'b1;
                        w_resp_data_nx        = w_rdata_mrg;
                    end
                end
            end
            MEM_ST_WRITE: if (r_iss < r_n) begin
                w_mem_a_nx    = w_iss_addr;
                w_mem_dout_nx = w_iss_byte;
                w_mem_wr_nx   = 1'b1;
                w_iss_nx      = r_iss + 3'd1;
            end else begin
                w_state_nx            = MEM_ST_IDLE;
                w_resp_valid_nx[r_ch] = 1'b1;
            end
            MEM_ST_IO_WAIT: if (!bus.io_buffer_full) begin
                w_state_nx    = MEM_ST_WRITE;
                w_mem_a_nx    = r_addr;
                w_mem_dout_nx = r_wdata[7:0];
                w_mem_wr_nx   = 1'b1;
                w_iss_nx      = 3'd1;
            end
            default: w_state_nx = MEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= MEM_ST_IDLE;
            r_ptr        <= '0;
            r_ch         <= '0;
            r_wr         <= 1'b0;
            r_n          <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_iss        <= '0;
            r_cap        <= '0;
            r_rdata      <= '0;
            r_rd_pipe    <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
            r_mem_wr     <= 1'b0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else if (rdy_in) begin
            r_state      <= w_state_nx;
            r_ptr        <= w_ptr_nx;
            r_ch         <= w_ch_nx;
            r_wr         <= w_wr_nx;
            r_n          <= w_n_nx;
            r_addr       <= w_addr_nx;
            r_wdata      <= w_wdata_nx;
            r_iss        <= w_iss_nx;
            r_cap        <= w_cap_nx;
            r_rdata      <= w_rdata_nx;
            r_rd_pipe    <= w_rd_pipe_nx;
            r_mem_a      <= w_mem_a_nx;
            r_mem_dout   <= w_mem_dout_nx;
            r_mem_wr     <= w_mem_wr_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_data  <= w_resp_data_nx;
        end
    end

    assign bus.mem_a      = r_mem_a;
    assign bus.mem_dout   = r_mem_dout;
    assign bus.mem_wr     = r_mem_wr & rdy_in;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign busy           = (r_state != MEM_ST_IDLE);

endmodule
